// File: rtl/al_accel_idemux_ctrl_if.sv
// Beat stream and demux-side signals of the input demux sequencer.
// The master drives beats in and observes row select, strobe and column address.
interface al_accel_idemux_ctrl_if #(
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       idemux_sel;
    logic [2:0]       row_wr_en;
    logic [CNT_W-1:0] col_addr;

    modport master (
        output in_valid,
        input  in_ready,
        input  idemux_sel,
        input  row_wr_en,
        input  col_addr
    );

    modport slave (
        input  in_valid,
        output in_ready,
        output idemux_sel,
        output row_wr_en,
        output col_addr
    );
endinterface

// File: rtl/al_accel_idemux_ctrl.sv
// Input demux sequencer: loads three row buffers from a 3-byte beat stream,
// then holds the window-ready flag until the compute engine consumes it.
module al_accel_idemux_ctrl #(
    parameter int ROW_LEN = 32,
    parameter int CNT_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ctrl_start,
    input  logic                    ctrl_abort,
    input  logic                    win_consume,
    output logic                    win_ready,
    output logic                    ctrl_busy,
    output logic                    ctrl_done,
    al_accel_idemux_ctrl_if.slave   dmx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(ROW_LEN - 1);

    state_t           state_r;
    logic [1:0]       sel_r;
    logic [CNT_W-1:0] col_r;
    logic             in_ready_r;
    logic             win_ready_r;
    logic             busy_r;
    logic             done_r;
    logic             in_ready_s;
    logic             beat_s;
    logic [2:0]       wr_en_s;

    // Abort gates the handshake combinationally so no beat lands in the abort cycle.
    always_comb begin
        in_ready_s = in_ready_r & ~ctrl_abort;
        beat_s     = dmx.in_valid & in_ready_s;
        wr_en_s    = 3'b000;
        if (beat_s) begin
            case (sel_r)
                2'd0:    wr_en_s = 3'b001;
                2'd1:    wr_en_s = 3'b010;
                2'd2:    wr_en_s = 3'b100;
                default: wr_en_s = 3'b000;
            endcase
        end else begin
            wr_en_s = 3'b000;
        end
    end

    // Sequencer state, row/column position and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            sel_r       <= 2'd0;
            col_r       <= '0;
            in_ready_r  <= 1'b0;
            win_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else if (ctrl_abort) begin
            state_r     <= IDLE;
            sel_r       <= 2'd0;
            col_r       <= '0;
            in_ready_r  <= 1'b0;
            win_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ctrl_start) begin
                        state_r    <= LOAD;
                        sel_r      <= 2'd0;
                        col_r      <= '0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat_s) begin
                        if (col_r == LAST_COL) begin
                            col_r <= '0;
                            if (sel_r == 2'd2) begin
                                state_r     <= FULL;
                                sel_r       <= 2'd0;
                                in_ready_r  <= 1'b0;
                                win_ready_r <= 1'b1;
                            end else begin
                                sel_r <= sel_r + 2'd1;
                            end
                        end else begin
                            col_r <= col_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                FULL: begin
                    if (win_consume) begin
                        state_r     <= IDLE;
                        win_ready_r <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    sel_r       <= 2'd0;
                    col_r       <= '0;
                    in_ready_r  <= 1'b0;
                    win_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign dmx.in_ready   = in_ready_s;
    assign dmx.row_wr_en  = wr_en_s;
    assign dmx.idemux_sel = sel_r;
    assign dmx.col_addr   = col_r;
    assign win_ready      = win_ready_r;
    assign ctrl_busy      = busy_r;
    assign ctrl_done      = done_r;

endmodule

// File: tb/tb_al_accel_idemux_ctrl.sv
// Scoreboard bench: stimulus queues expected write strobes, negedge monitors
// pop and compare whenever a DUT presents a strobe.
module tb_al_accel_idemux_ctrl;

    typedef struct packed {
        logic [2:0] wr;
        logic [1:0] sel;
        logic [4:0] col;
    } exp_t;

    logic clk;
    logic rst;
    logic start0, abort0, consume0, win_ready0, busy0, done0;
    logic start1, abort1, consume1, win_ready1, busy1, done1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];

    al_accel_idemux_ctrl_if #(.CNT_W(5)) dmx0 ();
    al_accel_idemux_ctrl_if #(.CNT_W(5)) dmx1 ();

    al_accel_idemux_ctrl #(.ROW_LEN(4), .CNT_W(5)) u0 (
        .clk(clk), .rst(rst), .ctrl_start(start0), .ctrl_abort(abort0),
        .win_consume(consume0), .win_ready(win_ready0), .ctrl_busy(busy0),
        .ctrl_done(done0), .dmx(dmx0.slave)
    );

    al_accel_idemux_ctrl #(.ROW_LEN(1), .CNT_W(5)) u1 (
        .clk(clk), .rst(rst), .ctrl_start(start1), .ctrl_abort(abort1),
        .win_consume(consume1), .win_ready(win_ready1), .ctrl_busy(busy1),
        .ctrl_done(done1), .dmx(dmx1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Beat i of a ROW_LEN=4 load: row i/4, column i%4.
    task automatic push0(input int i);
        exp_t e;
        e.sel = 2'(i / 4);
        e.col = 5'(i % 4);
        e.wr  = 3'b001 << e.sel;
        q0.push_back(e);
    endtask

    task automatic start_u0();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
    endtask

    task automatic beats_u0(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            dmx0.in_valid = 1'b1;
            push0(i);
            step();
        end
        dmx0.in_valid = 1'b0;
    endtask

    task automatic consume_u0();
        consume0 = 1'b1;
        step();
        consume0 = 1'b0;
        check("consume_done", 32'(done0), 32'd1);
        check("consume_busy", 32'(busy0), 32'd0);
        check("consume_in_ready", 32'(dmx0.in_ready), 32'd0);
        check("consume_win_ready", 32'(win_ready0), 32'd0);
        step();
        check("done_one_cycle", 32'(done0), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && dmx0.row_wr_en != 3'b000) begin
            if (q0.size() == 0) begin
                check("u0_unexpected_strobe", 32'(dmx0.row_wr_en), 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("u0_row_wr_en", 32'(dmx0.row_wr_en), 32'(e.wr));
                check("u0_idemux_sel", 32'(dmx0.idemux_sel), 32'(e.sel));
                check("u0_col_addr", 32'(dmx0.col_addr), 32'(e.col));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && dmx1.row_wr_en != 3'b000) begin
            if (q1.size() == 0) begin
                check("u1_unexpected_strobe", 32'(dmx1.row_wr_en), 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("u1_row_wr_en", 32'(dmx1.row_wr_en), 32'(e.wr));
                check("u1_idemux_sel", 32'(dmx1.idemux_sel), 32'(e.sel));
                check("u1_col_addr", 32'(dmx1.col_addr), 32'(e.col));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] tab1 [3];
        tab1 = '{3'b001, 3'b010, 3'b100};
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; consume0 = 1'b0; dmx0.in_valid = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; consume1 = 1'b0; dmx1.in_valid = 1'b0;
        #12;
        check("rst_in_ready", 32'(dmx0.in_ready), 32'd0);
        check("rst_sel", 32'(dmx0.idemux_sel), 32'd0);
        check("rst_col", 32'(dmx0.col_addr), 32'd0);
        check("rst_wr_en", 32'(dmx0.row_wr_en), 32'd0);
        check("rst_win_ready", 32'(win_ready0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        rst = 1'b0;
        step();

        // Continuous full load then consume.
        start_u0();
        check("load_in_ready", 32'(dmx0.in_ready), 32'd1);
        check("load_busy", 32'(busy0), 32'd1);
        beats_u0(0, 12);
        check("full_win_ready", 32'(win_ready0), 32'd1);
        check("full_in_ready", 32'(dmx0.in_ready), 32'd0);
        check("full_busy", 32'(busy0), 32'd1);
        check("full_q_drained", 32'(q0.size()), 32'd0);
        consume_u0();

        // Backpressure: valid on even cycles only; position holds in the gaps.
        start_u0();
        for (int k = 0; k < 23; k++) begin
            if (k % 2 == 0) begin
                dmx0.in_valid = 1'b1;
                push0(k / 2);
            end else begin
                dmx0.in_valid = 1'b0;
                check("gap_sel", 32'(dmx0.idemux_sel), 32'((k / 2 + 1) / 4));
                check("gap_col", 32'(dmx0.col_addr), 32'((k / 2 + 1) % 4));
                check("gap_win_ready", 32'(win_ready0), 32'd0);
            end
            step();
        end
        dmx0.in_valid = 1'b0;
        check("bp_win_ready", 32'(win_ready0), 32'd1);
        check("bp_q_drained", 32'(q0.size()), 32'd0);
        consume_u0();

        // Start and consume during LOAD are ignored.
        start_u0();
        beats_u0(0, 2);
        start0 = 1'b1;
        consume0 = 1'b1;
        step();
        start0 = 1'b0;
        consume0 = 1'b0;
        check("ign_sel", 32'(dmx0.idemux_sel), 32'd0);
        check("ign_col", 32'(dmx0.col_addr), 32'd2);
        check("ign_in_ready", 32'(dmx0.in_ready), 32'd1);
        check("ign_done", 32'(done0), 32'd0);

        // Abort on the sixth beat with valid high.
        beats_u0(2, 3);
        dmx0.in_valid = 1'b1;
        abort0 = 1'b1;
        #1;
        check("abort_wr_en", 32'(dmx0.row_wr_en), 32'd0);
        check("abort_in_ready", 32'(dmx0.in_ready), 32'd0);
        step();
        abort0 = 1'b0;
        dmx0.in_valid = 1'b0;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_sel", 32'(dmx0.idemux_sel), 32'd0);
        check("abort_col", 32'(dmx0.col_addr), 32'd0);
        check("abort_done", 32'(done0), 32'd0);
        start0 = 1'b1;
        abort0 = 1'b1;
        step();
        start0 = 1'b0;
        abort0 = 1'b0;
        check("start_abort_busy", 32'(busy0), 32'd0);
        check("start_abort_in_ready", 32'(dmx0.in_ready), 32'd0);
        start_u0();
        beats_u0(0, 12);
        check("restart_win_ready", 32'(win_ready0), 32'd1);
        consume_u0();

        // Asynchronous reset in the middle of row 1.
        start_u0();
        beats_u0(0, 7);
        check("pre_rst_sel", 32'(dmx0.idemux_sel), 32'd1);
        check("pre_rst_col", 32'(dmx0.col_addr), 32'd3);
        dmx0.in_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", 32'(dmx0.row_wr_en), 32'd0);
        check("mid_rst_in_ready", 32'(dmx0.in_ready), 32'd0);
        check("mid_rst_sel", 32'(dmx0.idemux_sel), 32'd0);
        check("mid_rst_col", 32'(dmx0.col_addr), 32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_win_ready", 32'(win_ready0), 32'd0);
        #2;
        rst = 1'b0;
        dmx0.in_valid = 1'b0;
        step();
        check("post_rst_busy", 32'(busy0), 32'd0);

        // ROW_LEN=1: every beat advances the row.
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.wr  = tab1[k];
            e.sel = 2'(k);
            e.col = 5'd0;
            q1.push_back(e);
            dmx1.in_valid = 1'b1;
            step();
        end
        dmx1.in_valid = 1'b0;
        check("r1_win_ready", 32'(win_ready1), 32'd1);
        check("r1_in_ready", 32'(dmx1.in_ready), 32'd0);
        consume1 = 1'b1;
        step();
        consume1 = 1'b0;
        check("r1_done", 32'(done1), 32'd1);
        check("r1_busy", 32'(busy1), 32'd0);
        step();

        check("end_q0_empty", 32'(q0.size()), 32'd0);
        check("end_q1_empty", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
